// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and types for the sorter result receiver
package sort_pkg;

   localparam int SORT_N      = 250;
   localparam int SORT_LENGTH = 32;
   localparam int SORT_IDX_W  = 9;

   typedef enum logic {
      RX_FILL,
      RX_DRAIN
   } rx_state_t;

   typedef struct packed {
      logic [SORT_LENGTH-1:0] data;
      logic [SORT_IDX_W-1:0]  index;
   } sort_pair_t;

endpackage

// File: rtl/sort_rank_buf.sv
// rtl/sort_rank_buf.sv - rank-ordered frame buffer, simple dual-port RAM with registered read
module sort_rank_buf #(
   parameter int DEPTH  = 250,
   parameter int WIDTH  = 41,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset on the array or read register so the tools can map this to block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sort_result_rx.sv
// rtl/sort_result_rx.sv - captures a sorted frame and replays it over valid/ready
// Optional order/index checking is built when SORT_CHECK_EN is defined.
module sort_result_rx
   import sort_pkg::*;
#(
   parameter int N      = SORT_N,
   parameter int LENGTH = SORT_LENGTH,
   parameter int IDX_W  = SORT_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_val,
   input  logic [LENGTH-1:0] in_data,
   input  logic [IDX_W-1:0]  in_index,
   input  logic              in_done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LENGTH-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic [IDX_W-1:0]  out_rank,
   output logic              out_last,
   output logic              busy,
   output logic              err_order,
   output logic              err_index,
   output logic              err_count,
   output logic              err_ovf,
   output logic [15:0]       frame_cnt
);

   localparam int W  = LENGTH + IDX_W;
   localparam int AW = $clog2(N);
   localparam logic [IDX_W-1:0] N_I    = IDX_W'(N);
   localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] ONE_I  = IDX_W'(1);

   rx_state_t        state, state_n;
   logic [IDX_W-1:0] wr_ptr, fetch_ptr, cnt, wr_cnt_upd;
   logic             fill_wr, fill_full, fill_short, drain_done, first;
   logic [W-1:0]     ram_q, skid_pair;
   logic [IDX_W-1:0] q_rank, skid_rank;
   logic             q_valid, skid_valid, pop, q_keep, skid_keep, rd_en;

   assign first      = (wr_ptr == '0);
   assign wr_cnt_upd = wr_ptr + (in_val ? ONE_I : '0);
   assign busy       = (state == RX_DRAIN) || !first;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RX_FILL;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      fill_wr    = 1'b0;
      fill_full  = 1'b0;
      fill_short = 1'b0;
      case (state)
         RX_FILL: begin
            fill_wr    = in_val;
            fill_full  = in_val && (wr_ptr == LAST_I);
            // a same-cycle pair counts before the in_done rule is applied
            fill_short = in_done && !fill_full && (wr_cnt_upd != '0);
            if (fill_full || fill_short) begin
               state_n = RX_DRAIN;
            end
         end
         RX_DRAIN: begin
            if (drain_done) begin
               state_n = RX_FILL;
            end
         end
         default: state_n = RX_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         cnt       <= '0;
         frame_cnt <= '0;
         err_count <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         if (drain_done) begin
            wr_ptr    <= '0;
            frame_cnt <= frame_cnt + 16'd1;
         end else if (fill_wr) begin
            wr_ptr <= wr_cnt_upd;
         end
         if (fill_full) begin
            cnt <= N_I;
         end else if (fill_short) begin
            cnt <= wr_cnt_upd;
         end
         if (fill_wr && first) begin
            err_count <= 1'b0;
            err_ovf   <= 1'b0;
         end
         if (fill_short) begin
            err_count <= 1'b1;
         end
         if ((state == RX_DRAIN) && in_val) begin
            err_ovf <= 1'b1;
         end
      end
   end

`ifdef SORT_CHECK_EN
   logic [LENGTH-1:0] prev_val;
   logic [N-1:0]      seen, seen_base, idx_hot;
   logic [IDX_W-1:0]  idx_m1;
   logic              idx_range, order_bad, index_bad;

   assign idx_m1    = in_index - ONE_I;
   assign idx_range = (in_index != '0) && (in_index <= N_I);
   assign seen_base = first ? '0 : seen;
   assign idx_hot   = idx_range ? ({{(N-1){1'b0}}, 1'b1} << idx_m1) : '0;
   assign order_bad = !first && (in_data > prev_val);
   assign index_bad = !idx_range || ((seen_base & idx_hot) != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_val  <= '0;
         seen      <= '0;
         err_order <= 1'b0;
         err_index <= 1'b0;
      end else if (fill_wr) begin
         prev_val  <= in_data;
         seen      <= seen_base | idx_hot;
         err_order <= (!first && err_order) || order_bad;
         err_index <= (!first && err_index) || index_bad;
      end
   end
`else
   assign err_order = 1'b0;
   assign err_index = 1'b0;
`endif

   sort_rank_buf #(
      .DEPTH (N),
      .WIDTH (W),
      .ADDR_W(AW)
   ) u_buf (
      .clk    (clk),
      .wr_en  (fill_wr),
      .wr_addr(wr_ptr[AW-1:0]),
      .wr_data({in_data, in_index}),
      .rd_en  (rd_en),
      .rd_addr(fetch_ptr[AW-1:0]),
      .rd_data(ram_q)
   );

   // Head of the replay is the skid entry when occupied, else the RAM output register.
   assign out_valid  = q_valid || skid_valid;
   assign pop        = out_valid && out_ready;
   assign out_last   = out_valid && (out_rank == cnt - ONE_I);
   assign drain_done = pop && out_last;
   assign q_keep     = q_valid && !(pop && !skid_valid);
   assign skid_keep  = skid_valid && !pop;
   assign rd_en      = (state == RX_DRAIN) && (fetch_ptr != cnt) && !(q_keep && skid_keep);

   always_comb begin
      out_data  = '0;
      out_index = '0;
      out_rank  = '0;
      if (skid_valid) begin
         {out_data, out_index} = skid_pair;
         out_rank              = skid_rank;
      end else if (q_valid) begin
         {out_data, out_index} = ram_q;
         out_rank              = q_rank;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_valid    <= 1'b0;
         q_rank     <= '0;
         skid_valid <= 1'b0;
         skid_rank  <= '0;
         skid_pair  <= '0;
         fetch_ptr  <= '0;
      end else if (drain_done) begin
         q_valid    <= 1'b0;
         skid_valid <= 1'b0;
         fetch_ptr  <= '0;
      end else if (rd_en) begin
         q_valid   <= 1'b1;
         q_rank    <= fetch_ptr;
         fetch_ptr <= fetch_ptr + ONE_I;
         // a surviving RAM entry must move aside before the new read overwrites it
         if (q_keep) begin
            skid_valid <= 1'b1;
            skid_pair  <= ram_q;
            skid_rank  <= q_rank;
         end else begin
            skid_valid <= skid_keep;
         end
      end else begin
         q_valid    <= q_keep;
         skid_valid <= skid_keep;
      end
   end

endmodule
